// File: rtl/sd_clk_pkg.sv
// Purpose : shared defaults and FSM state type for the SD bit-clock generator.
// Latency : n/a (types and constants only).
// Backpres: n/a.
package sd_clk_pkg;

    // pll0_250MHz cycles per output period, and slow edges before fast mode
    localparam int SD_DIV_FAST  = 25;   // 250 MHz / 25  = 10 MHz
    localparam int SD_DIV_SLOW  = 625;  // 250 MHz / 625 = 400 kHz
    localparam int SD_INIT_CLKS = 80;

    typedef enum logic [1:0] {
        SLOW      = 2'd0,
        WAIT_FAST = 2'd1,
        FAST      = 2'd2,
        WAIT_SLOW = 2'd3
    } sd_clk_state_t;

endpackage

// File: rtl/sd_clk_div.sv
// Purpose : divide-by-DIV clock with registered output, enable and phase reload.
// Latency : output reflects the counter value it is registered alongside; reload
//           takes effect on the same edge (first high phase full length).
// Backpres: none; en=0 holds counter and output at 0.
//
// Ports:
//   clk      in   sole clock
//   reset    in   synchronous, active-high
//   en       in   1 = run, 0 = counter and output forced to 0
//   reload   in   restart the period at count 0 (start of a high phase)
//   cnt      out  current phase counter, 0..DIV-1
//   clk_out  out  1 while cnt < DIV/2
module sd_clk_div #(
    parameter int DIV = 25
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     en,
    input  logic                     reload,
    output logic [$clog2(DIV)-1:0]   cnt,
    output logic                     clk_out
);

    localparam int W = $clog2(DIV);
    localparam logic [W-1:0] LAST = W'(DIV - 1);
    localparam logic [W-1:0] HALF = W'(DIV / 2);

    // Remembers whether the previous cycle was enabled. The first enabled
    // cycle after an idle period restarts at count 0 instead of advancing,
    // so the first high phase after enable is full length.
    logic           running;
    logic [W-1:0]   cnt_nxt;

    always_comb begin
        cnt_nxt = cnt;
        if (!en) begin
            cnt_nxt = '0;
        end else if (reload || !running) begin
            cnt_nxt = '0;
        end else if (cnt == LAST) begin
            cnt_nxt = '0;
        end else begin
            cnt_nxt = cnt + W'(1);
        end
    end

    // The output is registered from the next count so that clk_out and cnt
    // always describe the same phase.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt     <= '0;
            clk_out <= 1'b0;
            running <= 1'b0;
        end else begin
            cnt     <= cnt_nxt;
            clk_out <= en && (cnt_nxt < HALF);
            running <= en;
        end
    end

endmodule

// File: rtl/sd_clk_gen.sv
// Purpose : SD bit-clock generator: 10 MHz / 400 kHz dividers, init-clock
//           counter and glitch-free mux select sequencing.
// Latency : all outputs registered; request to switch_busy 1 cycle; a switch
//           completes at the end of the current clock's low phase.
// Backpres: none; clk_en=0 freezes the FSM and holds both clocks low.
//
// Ports:
//   pll0_250MHz  in   sole clock
//   reset        in   synchronous, active-high
//   clk_en       in   1 = clocks run, 0 = both clocks held low
//   speed_req    in   1 = request 10 MHz, 0 = request 400 kHz (level)
//   MHz10        out  divided fast clock
//   kHz400       out  divided slow clock
//   SDClkSelect  out  1 = downstream mux selects MHz10
//   switch_busy  out  a switch is pending
//   init_done    out  INIT_CLKS slow rising edges issued (sticky until reset)
module sd_clk_gen
    import sd_clk_pkg::*;
#(
    parameter int DIV_FAST  = SD_DIV_FAST,
    parameter int DIV_SLOW  = SD_DIV_SLOW,
    parameter int INIT_CLKS = SD_INIT_CLKS
) (
    input  logic pll0_250MHz,
    input  logic reset,
    input  logic clk_en,
    input  logic speed_req,
    output logic MHz10,
    output logic kHz400,
    output logic SDClkSelect,
    output logic switch_busy,
    output logic init_done
);

    localparam int FW = $clog2(DIV_FAST);
    localparam int SW = $clog2(DIV_SLOW);
    localparam int IW = $clog2(INIT_CLKS + 1);

    localparam logic [FW-1:0] F_LAST    = FW'(DIV_FAST - 1);
    localparam logic [SW-1:0] S_LAST    = SW'(DIV_SLOW - 1);
    localparam logic [IW-1:0] INIT_FULL = IW'(INIT_CLKS);
    localparam logic [IW-1:0] INIT_LAST = IW'(INIT_CLKS - 1);

    sd_clk_state_t  state;
    logic [FW-1:0]  cnt_f;
    logic [SW-1:0]  cnt_s;
    logic [IW-1:0]  init_cnt;
    logic           slow_prev;
    logic           go_fast;
    logic           go_slow;

    // A switch is taken only at the last low cycle of the clock being left,
    // so its final low phase is complete; the same edge restarts the new
    // clock at the start of its high phase.
    assign go_fast = clk_en && (state == WAIT_FAST) && (cnt_s == S_LAST);
    assign go_slow = clk_en && (state == WAIT_SLOW) && (cnt_f == F_LAST);

    sd_clk_div #(.DIV(DIV_FAST)) u_div_fast (
        .clk     (pll0_250MHz),
        .reset   (reset),
        .en      (clk_en),
        .reload  (go_fast),
        .cnt     (cnt_f),
        .clk_out (MHz10)
    );

    sd_clk_div #(.DIV(DIV_SLOW)) u_div_slow (
        .clk     (pll0_250MHz),
        .reset   (reset),
        .en      (clk_en),
        .reload  (go_slow),
        .cnt     (cnt_s),
        .clk_out (kHz400)
    );

    // Init counter: kHz400 only rises on an enabled edge, so every rise seen
    // on the registered output is counted even if clk_en drops right after.
    always_ff @(posedge pll0_250MHz) begin
        if (reset) begin
            init_cnt  <= '0;
            init_done <= 1'b0;
            slow_prev <= 1'b0;
        end else begin
            slow_prev <= kHz400;
            if (kHz400 && !slow_prev && (init_cnt != INIT_FULL)) begin
                init_cnt <= init_cnt + IW'(1);
                if (init_cnt == INIT_LAST) begin
                    init_done <= 1'b1;
                end
            end
        end
    end

    // Switch FSM. The switch condition wins over a simultaneous request
    // change; the new request is then seen from the destination state.
    always_ff @(posedge pll0_250MHz) begin
        if (reset) begin
            state       <= SLOW;
            SDClkSelect <= 1'b0;
            switch_busy <= 1'b0;
        end else if (clk_en) begin
            case (state)
                SLOW: begin
                    if (speed_req && init_done) begin
                        state       <= WAIT_FAST;
                        switch_busy <= 1'b1;
                    end
                end
                WAIT_FAST: begin
                    if (go_fast) begin
                        state       <= FAST;
                        SDClkSelect <= 1'b1;
                        switch_busy <= 1'b0;
                    end else if (!speed_req) begin
                        state       <= SLOW;
                        switch_busy <= 1'b0;
                    end
                end
                FAST: begin
                    if (!speed_req) begin
                        state       <= WAIT_SLOW;
                        switch_busy <= 1'b1;
                    end
                end
                WAIT_SLOW: begin
                    if (go_slow) begin
                        state       <= SLOW;
                        SDClkSelect <= 1'b0;
                        switch_busy <= 1'b0;
                    end else if (speed_req) begin
                        // abort: MHz10 never left the mux, keep its phase
                        state       <= FAST;
                        switch_busy <= 1'b0;
                    end
                end
                default: begin
                    state       <= SLOW;
                    SDClkSelect <= 1'b0;
                    switch_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sd_clk_gen.sv
// Directed bench for sd_clk_gen with default divider settings.
// Outputs are sampled 1 time unit after each rising edge.
module tb_sd_clk_gen;

    logic pll0_250MHz = 1'b0;
    logic reset;
    logic clk_en;
    logic speed_req;
    logic MHz10;
    logic kHz400;
    logic SDClkSelect;
    logic switch_busy;
    logic init_done;

    int errors = 0;
    int checks = 0;

    // muxed-clock run-length monitor
    logic mon_en    = 1'b0;
    logic mon_first = 1'b1;
    logic mon_prev  = 1'b0;
    int   mon_run   = 0;
    int   min_run   = 9999;

    logic sel_seen;
    logic busy_seen;
    int   mf_hi;
    int   ks_hi;

    sd_clk_gen dut (
        .pll0_250MHz (pll0_250MHz),
        .reset       (reset),
        .clk_en      (clk_en),
        .speed_req   (speed_req),
        .MHz10       (MHz10),
        .kHz400      (kHz400),
        .SDClkSelect (SDClkSelect),
        .switch_busy (switch_busy),
        .init_done   (init_done)
    );

    always #2 pll0_250MHz = ~pll0_250MHz;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        logic mux;
        @(posedge pll0_250MHz);
        #1;
        mux = SDClkSelect ? MHz10 : kHz400;
        if (mon_en) begin
            if (mux == mon_prev) begin
                mon_run++;
            end else begin
                if (!mon_first && mon_run < min_run) min_run = mon_run;
                mon_first = 1'b0;
                mon_run   = 1;
            end
        end
        mon_prev = mux;
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) begin
            step();
            if (SDClkSelect) sel_seen = 1'b1;
            if (switch_busy) busy_seen = 1'b1;
        end
    endtask

    task automatic mon_start();
        mon_first = 1'b1;
        mon_run   = 0;
        mon_en    = 1'b1;
    endtask

    initial begin
        reset     = 1'b1;
        clk_en    = 1'b1;
        speed_req = 1'b1;
        mf_hi     = 0;
        ks_hi     = 0;
        sel_seen  = 1'b0;
        busy_seen = 1'b0;

        // ---- reset state
        repeat (3) step();
        chk("rst_MHz10",  MHz10,       0);
        chk("rst_kHz400", kHz400,      0);
        chk("rst_sel",    SDClkSelect, 0);
        chk("rst_busy",   switch_busy, 0);
        chk("rst_init",   init_done,   0);

        // ---- free-running dividers and init sequence, speed_req held high.
        // Sample i follows the (i+1)-th edge after release: cnt = i mod DIV.
        reset = 1'b0;
        step();
        for (int i = 0; i <= 50000; i++) begin
            if (i < 50000 && SDClkSelect) sel_seen = 1'b1;
            if (i < 25)  mf_hi += int'(MHz10);
            if (i < 625) ks_hi += int'(kHz400);
            case (i)
                0: begin
                    chk("first_MHz10_hi",  MHz10,  1);
                    chk("first_kHz400_hi", kHz400, 1);
                end
                11:    chk("MHz10_last_hi",   MHz10,  1);
                12:    chk("MHz10_first_lo",  MHz10,  0);
                24:    chk("MHz10_last_lo",   MHz10,  0);
                25:    chk("MHz10_rehigh",    MHz10,  1);
                311:   chk("kHz400_last_hi",  kHz400, 1);
                312:   chk("kHz400_first_lo", kHz400, 0);
                624:   chk("kHz400_last_lo",  kHz400, 0);
                625:   chk("kHz400_rehigh",   kHz400, 1);
                49375: chk("init_before",     init_done, 0);
                49376: begin
                    chk("init_after",  init_done,   1);
                    chk("busy_pre",    switch_busy, 0);
                end
                49377: chk("busy_wait_fast", switch_busy, 1);
                49999: begin
                    chk("sel_before_switch",  SDClkSelect, 0);
                    chk("busy_before_switch", switch_busy, 1);
                end
                50000: begin
                    chk("sel_fast",        SDClkSelect, 1);
                    chk("MHz10_at_switch", MHz10,       1);
                    chk("busy_fast",       switch_busy, 0);
                end
                default: ;
            endcase
            if (i < 50000) step();
        end
        chk("MHz10_high_count",  mf_hi, 12);
        chk("kHz400_high_count", ks_hi, 312);
        chk("sel_before_init",   sel_seen, 0);

        // ---- FAST -> SLOW. t counts samples from the FAST entry (cnt_f = t)
        mon_start();
        repeat (5) step();                       // t=5
        speed_req = 1'b0;
        step();                                  // t=6
        chk("busy_wait_slow", switch_busy, 1);
        chk("sel_wait_slow",  SDClkSelect, 1);
        repeat (18) step();                      // t=24
        chk("sel_last_fast_lo", SDClkSelect, 1);
        chk("MHz10_last_lo_fs", MHz10,       0);
        step();                                  // t=25
        chk("sel_slow",         SDClkSelect, 0);
        chk("kHz400_at_switch", kHz400,      1);
        chk("busy_slow",        switch_busy, 0);

        // ---- WAIT_FAST abort (cnt_s = t-25)
        repeat (5) step();                       // t=30
        speed_req = 1'b1;
        sel_seen  = 1'b0;
        step();                                  // t=31
        chk("busy_abort_wait", switch_busy, 1);
        run(69);                                 // t=100
        speed_req = 1'b0;
        step();                                  // t=101
        chk("busy_abort_done", switch_busy, 0);
        busy_seen = 1'b0;
        run(559);                                // t=660
        chk("sel_never_abort",  sel_seen,  0);
        chk("busy_after_abort", busy_seen, 0);

        // ---- clk_en dropped while in WAIT_FAST
        mon_en    = 1'b0;
        speed_req = 1'b1;
        step();                                  // t=661
        chk("busy_wait_fast2", switch_busy, 1);
        clk_en = 1'b0;
        sel_seen = 1'b0;
        step();
        chk("dis_MHz10",  MHz10,  0);
        chk("dis_kHz400", kHz400, 0);
        run(99);                                 // 100 disabled edges
        chk("dis_MHz10_end",  MHz10,       0);
        chk("dis_kHz400_end", kHz400,      0);
        chk("dis_busy_held",  switch_busy, 1);
        chk("dis_sel_held",   sel_seen,    0);

        // r counts samples after re-enable; cnt_s = r-1
        clk_en = 1'b1;
        step();                                  // r=1
        chk("reen_MHz10",  MHz10,  1);
        chk("reen_kHz400", kHz400, 1);
        mon_start();
        run(624);                                // r=625
        chk("reen_sel_pre",  sel_seen,    0);
        chk("reen_busy_pre", switch_busy, 1);
        step();                                  // r=626
        chk("reen_sel_fast",  SDClkSelect, 1);
        chk("reen_MHz10_hi",  MHz10,       1);
        chk("reen_busy_done", switch_busy, 0);
        repeat (14) step();
        mon_en = 1'b0;
        chk("no_runt", min_run >= 12, 1);

        // ---- reset while in FAST
        reset = 1'b1;
        step();
        chk("rst2_sel",    SDClkSelect, 0);
        chk("rst2_MHz10",  MHz10,       0);
        chk("rst2_kHz400", kHz400,      0);
        chk("rst2_busy",   switch_busy, 0);
        chk("rst2_init",   init_done,   0);
        reset     = 1'b0;
        sel_seen  = 1'b0;
        busy_seen = 1'b0;
        run(2000);
        chk("rst2_req_ignored_sel",  sel_seen,  0);
        chk("rst2_req_ignored_busy", busy_seen, 0);
        chk("rst2_init_low",         init_done, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
